// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-side types.
//   ramstate_t    : status reported by the RAM model / controller each cycle
//   arb_state_t   : memory_arbiter control states
//   ARB_ERR_WORD  : value returned on a failed or timed-out access
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        HIT    = 2'd3
    } arb_state_t;

    localparam logic [31:0] ARB_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
// Single-port RAM arbiter between the instruction fetch port and the data
// port. One access is outstanding at a time; data requests win over
// instruction requests. Every RAM-facing and CPU-facing output is registered.
//
// Ports
//   CLK, nRST             clock (rising edge), async active-low reset
//   imemREN, imemaddr     instruction read request (level, held until ihit)
//   dmemREN, dmemWEN      data read / write request (level, held until dhit)
//   dmemaddr, dmemstore   data address / write data
//   ihit, imemload        instruction completion pulse and fetched word
//   dhit, dmemload        data completion pulse and read word
//   ramREN, ramWEN        RAM strobes (mutually exclusive)
//   ramaddr, ramstore     granted address / write data (from grant registers)
//   ramload, ramstate     RAM read data and status
//   memerr                sticky error flag (conflicting op, RAM error, timeout)
// ----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    logic              r_wr;        // latched op of the granted data access
    logic [31:0]       r_addr;
    logic [31:0]       r_store;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ihit;
    logic              r_dhit;
    logic              r_ramREN;
    logic              r_ramWEN;
    logic              r_memerr;
    logic [31:0]       r_iload;
    logic [31:0]       r_dload;

    ramstate_t         w_rs;
    logic              w_dside;
    logic              w_req_held;
    logic              w_fail;

    assign w_rs    = ramstate_t'(ramstate);
    assign w_dside = (r_state == D_WAIT);

    // The line that must stay high for the granted access to remain live.
    // A conflicting read+write grant is carried out as a write, so it is
    // tracked on dmemWEN.
    assign w_req_held = w_dside ? (r_wr ? dmemWEN : dmemREN) : imemREN;

    // RAM-reported error or the last permitted WAIT cycle passing idle.
    assign w_fail = (w_rs == ERROR) || (r_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_store  <= '0;
            r_cnt    <= '0;
            r_ihit   <= 1'b0;
            r_dhit   <= 1'b0;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            r_memerr <= 1'b0;
            r_iload  <= '0;
            r_dload  <= '0;
        end else begin
            // Hits are single-cycle; only the WAIT->HIT transition raises one.
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (dmemWEN || dmemREN) begin
                        r_state  <= D_WAIT;
                        r_addr   <= dmemaddr;
                        r_store  <= dmemstore;
                        r_wr     <= dmemWEN;
                        r_ramWEN <= dmemWEN;
                        r_ramREN <= ~dmemWEN;
                        r_cnt    <= '0;
                        if (dmemWEN && dmemREN) begin
                            r_memerr <= 1'b1;
                        end
                    end else if (imemREN) begin
                        r_state  <= I_WAIT;
                        r_addr   <= imemaddr;
                        r_store  <= '0;
                        r_wr     <= 1'b0;
                        r_ramWEN <= 1'b0;
                        r_ramREN <= 1'b1;
                        r_cnt    <= '0;
                    end
                end

                I_WAIT, D_WAIT: begin
                    if (w_rs == ACCESS) begin
                        // Completion beats a same-cycle request drop.
                        r_state  <= HIT;
                        r_ramREN <= 1'b0;
                        r_ramWEN <= 1'b0;
                        if (w_dside) begin
                            r_dhit <= 1'b1;
                            if (!r_wr) begin
                                r_dload <= ramload;
                            end
                        end else begin
                            r_ihit  <= 1'b1;
                            r_iload <= ramload;
                        end
                    end else if (!w_req_held) begin
                        // Requester withdrew: abandon silently.
                        r_state  <= IDLE;
                        r_ramREN <= 1'b0;
                        r_ramWEN <= 1'b0;
                    end else if (w_fail) begin
                        r_state  <= HIT;
                        r_ramREN <= 1'b0;
                        r_ramWEN <= 1'b0;
                        r_memerr <= 1'b1;
                        if (w_dside) begin
                            r_dhit  <= 1'b1;
                            r_dload <= ARB_ERR_WORD;
                        end else begin
                            r_ihit  <= 1'b1;
                            r_iload <= ARB_ERR_WORD;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // HIT gives the requester one cycle to see its hit before
                // the next arbitration in IDLE.
                HIT: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign imemload = r_iload;
    assign dmemload = r_dload;
    assign ramREN   = r_ramREN;
    assign ramWEN   = r_ramWEN;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign memerr   = r_memerr;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit, ramREN, ramWEN, memerr;
    logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model state
    logic        exp_memerr;
    logic [31:0] exp_iload, exp_dload;

    always #5 CLK = ~CLK;

    memory_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .imemload(imemload),
        .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr)
    );

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        imemREN  = 1'b0;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        ramstate = FREE;
    endtask

    task automatic model_reset();
        exp_memerr = 1'b0;
        exp_iload  = '0;
        exp_dload  = '0;
    endtask

    // kind: 0 = ifetch, 1 = data read, 2 = data write, 3 = read+write conflict
    // nbusy BUSY cycles precede the terminating status (ACCESS or ERROR).
    task automatic do_txn(input int kind, input logic [31:0] addr,
                          input logic [31:0] store, input int nbusy,
                          input logic end_err, input logic [31:0] rdata,
                          input string name);
        int         exp_w;
        logic       err;
        logic [3:0] strb;
        logic [3:0] hitv;
        exp_w = (nbusy >= TIMEOUT) ? TIMEOUT : nbusy + 1;
        err   = end_err || (nbusy >= TIMEOUT);
        strb  = (kind <= 1) ? 4'b0010 : 4'b0001;
        hitv  = (kind == 0) ? 4'b1000 : 4'b0100;

        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s idle: {ihit,dhit,REN,WEN} got %b want 0000", name, {ihit, dhit, ramREN, ramWEN});
        end
        if (kind == 0) begin
            imemREN  = 1'b1;
            imemaddr = addr;
        end else begin
            dmemaddr  = addr;
            dmemstore = store;
            dmemREN   = (kind == 1) || (kind == 3);
            dmemWEN   = (kind >= 2);
        end
        ramstate = FREE;

        for (int i = 1; i <= exp_w; i++) begin
            cyc();
            n_vec++;
            if ({ihit, dhit, ramREN, ramWEN} !== strb || ramaddr !== addr) begin
                n_err++;
                $display("FAIL %s wait%0d: flags got %b want %b, ramaddr got %h want %h",
                         name, i, {ihit, dhit, ramREN, ramWEN}, strb, ramaddr, addr);
            end
            if (kind >= 2) begin
                n_vec++;
                if (ramstore !== store) begin
                    n_err++;
                    $display("FAIL %s ramstore: got %h want %h", name, ramstore, store);
                end
            end
            ramstate = (i <= nbusy) ? BUSY : (end_err ? ERROR : ACCESS);
            ramload  = (i == exp_w) ? rdata : $urandom;
        end

        exp_memerr = exp_memerr | err | (kind == 3);
        if (kind == 0)     exp_iload = err ? ARB_ERR_WORD : rdata;
        else if (err)      exp_dload = ARB_ERR_WORD;
        else if (kind == 1) exp_dload = rdata;

        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== hitv || imemload !== exp_iload ||
            dmemload !== exp_dload || memerr !== exp_memerr) begin
            n_err++;
            $display("FAIL %s hit: flags got %b want %b, iload %h/%h dload %h/%h memerr %b/%b",
                     name, {ihit, dhit, ramREN, ramWEN}, hitv, imemload, exp_iload,
                     dmemload, exp_dload, memerr, exp_memerr);
        end
        idle_inputs();

        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 || imemload !== exp_iload ||
            dmemload !== exp_dload || memerr !== exp_memerr) begin
            n_err++;
            $display("FAIL %s after: flags got %b want 0000, iload %h/%h dload %h/%h memerr %b/%b",
                     name, {ihit, dhit, ramREN, ramWEN}, imemload, exp_iload,
                     dmemload, exp_dload, memerr, exp_memerr);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0;
        model_reset();
        repeat (2) cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN, memerr} !== 5'b0 || imemload !== 32'd0 ||
            dmemload !== 32'd0 || ramaddr !== 32'd0 || ramstore !== 32'd0) begin
            n_err++;
            $display("FAIL reset: flags got %b want 00000, iload %h dload %h addr %h store %h",
                     {ihit, dhit, ramREN, ramWEN, memerr}, imemload, dmemload, ramaddr, ramstore);
        end
        nRST = 1'b1;
    endtask

    task automatic test_ifetch();
        do_txn(0, 32'h40, 32'h0, 2, 1'b0, 32'h8C010004, "ifetch");
    endtask

    task automatic test_write();
        do_txn(2, 32'h200, 32'hDEADBEEF, 0, 1'b0, 32'h12345678, "write");
    endtask

    task automatic test_priority();
        logic [31:0] dv, iv;
        dv = $urandom;
        iv = $urandom;
        cyc();
        imemREN = 1'b1; imemaddr = 32'h80;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        ramstate = FREE;
        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0010 || ramaddr !== 32'h100) begin
            n_err++;
            $display("FAIL prio dgrant: flags %b want 0010, addr %h want 00000100", {ihit, dhit, ramREN, ramWEN}, ramaddr);
        end
        ramstate = ACCESS; ramload = dv;
        exp_dload = dv;
        cyc();
        n_vec++;
        if ({ihit, dhit} !== 2'b01 || dmemload !== exp_dload) begin
            n_err++;
            $display("FAIL prio dhit: {ihit,dhit} %b want 01, dload %h want %h", {ihit, dhit}, dmemload, exp_dload);
        end
        dmemREN = 1'b0; ramstate = FREE;
        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            n_err++;
            $display("FAIL prio idle: flags %b want 0000", {ihit, dhit, ramREN, ramWEN});
        end
        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0010 || ramaddr !== 32'h80) begin
            n_err++;
            $display("FAIL prio igrant: flags %b want 0010, addr %h want 00000080", {ihit, dhit, ramREN, ramWEN}, ramaddr);
        end
        ramstate = ACCESS; ramload = iv;
        exp_iload = iv;
        cyc();
        n_vec++;
        if ({ihit, dhit} !== 2'b10 || imemload !== exp_iload) begin
            n_err++;
            $display("FAIL prio ihit: {ihit,dhit} %b want 10, iload %h want %h", {ihit, dhit}, imemload, exp_iload);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_abort();
        cyc();
        dmemREN = 1'b1; dmemaddr = 32'h300; ramstate = FREE;
        cyc();
        ramstate = BUSY;
        cyc();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0010) begin
            n_err++;
            $display("FAIL abort wait2: flags %b want 0010", {ihit, dhit, ramREN, ramWEN});
        end
        dmemREN = 1'b0; ramstate = BUSY;
        cyc();
        ramstate = ACCESS; ramload = $urandom;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 || dmemload !== exp_dload) begin
                n_err++;
                $display("FAIL abort post%0d: flags %b want 0000, dload %h want %h",
                         i, {ihit, dhit, ramREN, ramWEN}, dmemload, exp_dload);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_txn(1, 32'h44, 32'h0, TIMEOUT + 10, 1'b0, 32'h0, "timeout");
    endtask

    task automatic test_conflict();
        do_txn(3, 32'h500, 32'hCAFEF00D, 1, 1'b0, 32'h0, "conflict");
    endtask

    task automatic test_back_to_back();
        int kind, nb;
        logic e;
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 2);
            nb   = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : $urandom_range(0, 4);
            e    = ($urandom_range(0, 7) == 0);
            do_txn(kind, $urandom, $urandom, nb, e, $urandom, "random");
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        dmemREN = 1'b1; dmemaddr = 32'h600; ramstate = FREE;
        cyc();
        ramstate = BUSY;
        #1 nRST = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({ihit, dhit, ramREN, ramWEN, memerr} !== 5'b0 || imemload !== 32'd0 ||
            dmemload !== 32'd0 || ramaddr !== 32'd0 || ramstore !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: flags got %b want 00000, iload %h dload %h addr %h store %h",
                     {ihit, dhit, ramREN, ramWEN, memerr}, imemload, dmemload, ramaddr, ramstore);
        end
        cyc();
        nRST = 1'b1;
        dmemREN = 1'b0;
        ramstate = ACCESS;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if ({ihit, dhit, ramREN, ramWEN, memerr} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_mid post%0d: flags %b want 00000", i, {ihit, dhit, ramREN, ramWEN, memerr});
            end
        end
        idle_inputs();
        do_txn(1, 32'h700, 32'h0, 1, 1'b0, 32'hA5A55A5A, "after_reset");
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_write();
        test_priority();
        test_abort();
        test_timeout();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Cross-check invariants on every cycle, independently of the scenarios.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && ((ihit && dhit) || (ramREN && ramWEN))) begin
            n_vec++;
            n_err++;
            $display("FAIL exclusive: ihit %b dhit %b ramREN %b ramWEN %b", ihit, dhit, ramREN, ramWEN);
        end
    end

endmodule
